if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It produces InstructionD and PCPlus4D for the decode stage. It consumes the decode stage's redirect outputs: PCSrcD/PCBranchD and JumpD/JumpTarget. It owns the PC register, the IF/ID pipeline register, a single-entry hold buffer and a wait-state instruction-memory handshake.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble instruction written into IF/ID (sll $0,$0,0).
DELAY_SLOT, 0, 1 = the instruction after a branch/jump is executed; 0 = it is squashed.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-low reset.
StallF  in  1  hazard unit: hold PC / do not hand off a new fetch.
StallD  in  1  hazard unit: hold IF/ID; decode redirect inputs ignored while high.
PCSrcD  in  1  taken branch resolved in decode.
PCBranchD  in  32  branch target.
JumpD  in  1  j/jal/jr in decode.
JumpTarget  in  32  jump target (already jr-selected).
imem_req  out  1  fetch request; imem_addr valid while high.
imem_addr  out  32  word address = PC.
imem_rdata  in  32  instruction; valid when imem_ready=1.
imem_ready  in  1  rdata corresponds to current imem_addr this cycle.
InstructionD  out  32  IF/ID instruction.
PCPlus4D  out  32  IF/ID PC+4.
ValidD  out  1  IF/ID holds a real instruction (0 = bubble).
FetchBusy  out  1  memory wait in progress; the hazard unit ORs this into the stall.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, InstructionD=NOP_INSTR, PCPlus4D=0, ValidD=0, state=FETCH, hold buffer empty, pending redirect cleared, imem_req=0. imem_req=1 from the first clock after release.
- Redirect: redir = (JumpD | PCSrcD) & ~StallD. Target = JumpTarget if JumpD, else PCBranchD (jump has priority). PC+4 is computed modulo 2^32.
- State FETCH: imem_req=1, imem_addr=PC.
  - imem_ready & ~StallF: IF/ID <= {imem_rdata, PC+4}, ValidD=1, PC <= PC+4.
  - imem_ready & StallF: buffer <= imem_rdata, PC <= PC+4, go HOLD, IF/ID unchanged.
  - ~imem_ready: FetchBusy=1. If ~StallD, IF/ID <= bubble (NOP_INSTR, ValidD=0, PCPlus4D unchanged).
- State HOLD: imem_req=0. When StallF=0: IF/ID <= buffer, ValidD=1, go FETCH. IF/ID PCPlus4D = PC at entry to HOLD.
- StallD=1 always freezes all IF/ID fields. The hazard unit guarantees StallF=1 whenever StallD=1.
- DELAY_SLOT=0, redirect cycle:
  - PC <= target, buffer discarded, state <= FETCH.
  - Any imem_ready data that cycle is dropped.
  - IF/ID <= bubble.
  - Latency: target on imem_addr the cycle after the redirect.
- DELAY_SLOT=1, redirect cycle:
  - Target goes to a pending register.
  - The current fetch (or buffered instruction) completes and is delivered normally.
  - On the cycle that hand-off occurs, PC <= pending target and pending clears.
  - A second redirect while pending is set overwrites pending.
- imem_addr may change while imem_req=1 only on redirect or PC advance. Memory must evaluate ready/rdata against the current address.
- Reset mid-wait: the outstanding request is abandoned; the next request is at RESET_PC.

Test Plan:
- Zero-wait stream: imem_ready=1 constantly, RESET_PC=0 -> imem_addr 0,4,8,... one per cycle; InstructionD follows one cycle later; PCPlus4D=4,8,12; ValidD=1 from cycle 2.
- Wait states: imem_ready low 2 cycles at addr 0x8 -> FetchBusy=1 for 2 cycles; two bubbles (ValidD=0); then the instruction at 0x8 arrives with PCPlus4D=0xC.
- Stall with data ready: StallF=StallD=1 for 3 cycles while ready at 0x10 -> HOLD, imem_req=0, IF/ID frozen; on release InstructionD=mem[0x10], PCPlus4D=0x14, next imem_addr=0x14.
- Branch, DELAY_SLOT=0: PCSrcD=1, PCBranchD=0x40 -> next imem_addr=0x40, IF/ID bubble; PCSrcD=1 with StallD=1 -> ignored. JumpD and PCSrcD both set -> JumpTarget used.
- Branch, DELAY_SLOT=1, with memory wait: redirect to 0x80 while slot fetch at 0x24 waits 1 cycle -> 0x24 is delivered with ValidD=1, then imem_addr=0x80.
- Async reset asserted mid-wait and mid-HOLD -> outputs reach reset values without a clock edge; after release the first imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID register, a one-entry hold buffer and the imem handshake.
// Latency: fetched instruction appears on InstructionD one cycle after imem_ready; a redirect target is on imem_addr the next cycle.
// Backpressure: imem wait raises FetchBusy; StallF parks a ready word in the hold buffer; StallD freezes IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter int          DELAY_SLOT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] JumpTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] InstructionD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic        active;      // low for the first cycle after reset so no request is issued yet
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        pend_vld;
    logic [31:0] pend_tgt;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic        handoff;
    logic        fetch_ok;

    assign imem_req  = active & (state == FETCH);
    assign imem_addr = pc;
    assign FetchBusy = imem_req & ~imem_ready;

    // Redirect decode, PC increment and the "instruction handed to decode this cycle" strobe.
    always_comb begin
        redir     = (JumpD | PCSrcD) & ~StallD;
        redir_tgt = JumpD ? JumpTarget : PCBranchD;
        pc_plus4  = pc + 32'd4;
        fetch_ok  = imem_req & imem_ready;
        handoff   = active & ~StallF & ((state == HOLD) | ((state == FETCH) & imem_ready));
    end

    // Fetch FSM, PC, hold buffer, pending redirect and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH;
            active       <= 1'b0;
            pc           <= RESET_PC;
            hold_buf     <= NOP_INSTR;
            pend_vld     <= 1'b0;
            pend_tgt     <= RESET_PC;
            InstructionD <= NOP_INSTR;
            PCPlus4D     <= 32'h0000_0000;
            ValidD       <= 1'b0;
        end else begin
            active <= 1'b1;
            if (active) begin
                if (DELAY_SLOT == 0 && redir) begin
                    // Squash: drop any returning word and the buffer, refetch from the target.
                    pc           <= redir_tgt;
                    state        <= FETCH;
                    InstructionD <= NOP_INSTR;
                    ValidD       <= 1'b0;
                end else begin
                    case (state)
                        FETCH: begin
                            if (fetch_ok) begin
                                pc <= pc_plus4;
                                if (!StallF) begin
                                    InstructionD <= imem_rdata;
                                    PCPlus4D     <= pc_plus4;
                                    ValidD       <= 1'b1;
                                end else begin
                                    hold_buf <= imem_rdata;
                                    state    <= HOLD;
                                end
                            end else if (!StallD) begin
                                InstructionD <= NOP_INSTR;
                                ValidD       <= 1'b0;
                            end
                        end
                        HOLD: begin
                            // PC already advanced on entry, so it is the buffered word's PC+4.
                            if (!StallF) begin
                                InstructionD <= hold_buf;
                                PCPlus4D     <= pc;
                                ValidD       <= 1'b1;
                                state        <= FETCH;
                            end
                        end
                        default: state <= FETCH;
                    endcase

                    // Delay slot: the redirect takes effect when the slot instruction is handed off.
                    if (DELAY_SLOT != 0) begin
                        if (handoff && (redir || pend_vld)) begin
                            pc       <= redir ? redir_tgt : pend_tgt;
                            pend_vld <= 1'b0;
                        end else if (redir) begin
                            pend_vld <= 1'b1;
                            pend_tgt <= redir_tgt;
                        end
                    end
                end
            end
        end
    end

endmodule
